instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rv32i_pkg.sv | 13 +
 rtl/instr_fetch_if.sv | 42 ++++
 rtl/pc_unit.sv | 43 ++++
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: NOP encoding, fetch FSM states,
// and the sequential PC increment.
package rv32i_pkg;

    localparam logic [31:0] NOP_ENC = 32'h0000_0013;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: downstream control, ROM port and IF/ID outputs.
// master = fetch stage, slave = ROM / decode side.
interface instr_fetch_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [31:0] fetch_count;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_data,
        output imem_addr,
        output if_pc,
        output if_pc_plus4,
        output if_instr,
        output if_valid,
        output fetch_count
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output imem_data,
        input  imem_addr,
        input  if_pc,
        input  if_pc_plus4,
        input  if_instr,
        input  if_valid,
        input  fetch_count
    );

endinterface

// File: rtl/pc_unit.sv
// PC register with next-PC mux.
// Ports: clk, reset, boot, stall, redirect, redirect_pc in; pc out.
module pc_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    logic [31:0] target;
    logic        do_hold;
    logic        do_jump;
    logic        do_step;

    // Targets are forced word aligned.
    assign target = redirect_pc & ~32'h3;

    // Boot holds; redirect beats stall.
    assign do_hold = boot | (!redirect & stall);
    assign do_jump = !boot & redirect;
    assign do_step = !boot & !redirect & !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            unique case (1'b1)
                do_hold: pc <= pc;
                do_jump: pc <= target;
                do_step: pc <= pc + PC_INC;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: boot FSM, PC unit, IF/ID register, fetch counter.
// Ports: clk, reset; bus (instr_fetch_if.master) carries control, ROM and IF/ID.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         boot;
    logic         do_bubble;
    logic         do_hold;
    logic         do_fetch;

    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         valid_q;
    logic [31:0]  count_q;

    assign boot = (state == BOOT);

    // Mutually exclusive actions for the IF/ID register.
    assign do_bubble = boot | bus.redirect_valid;
    assign do_hold   = !do_bubble & bus.stall;
    assign do_fetch  = !do_bubble & !bus.stall;

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .boot        (boot),
        .stall       (bus.stall),
        .redirect    (bus.redirect_valid),
        .redirect_pc (bus.redirect_pc),
        .pc          (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= RUN;
        end
    end

    // Bubbles keep if_pc so downstream still sees the last real PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            unique case (1'b1)
                do_bubble: begin
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                end
                do_hold: begin
                    instr_q <= instr_q;
                end
                do_fetch: begin
                    pc_q    <= pc;
                    instr_q <= bus.imem_data;
                    valid_q <= 1'b1;
                    count_q <= count_q + 32'd1;
                end
                default: begin
                    instr_q <= instr_q;
                end
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_pc       = pc_q;
    assign bus.if_pc_plus4 = pc_q + PC_INC;
    assign bus.if_instr    = instr_q;
    assign bus.if_valid    = valid_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural project ROM.
// Ports: none; drives clk/reset and the fetch bus interface.
module tb_instr_fetch;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    instr_fetch_if ifc ();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0011_0233;
            32'h0000_0004: rom = 32'h0020_8093;
            32'h0000_0008: rom = 32'h0031_0113;
            32'h0000_000C: rom = 32'h0041_8193;
            default:       rom = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign ifc.imem_data = rom(ifc.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    ifc.if_pc,       32'h0);
        chk({tag, "_instr"}, ifc.if_instr,    32'h0000_0013);
        chk({tag, "_valid"}, {31'd0, ifc.if_valid}, 32'h0);
        chk({tag, "_cnt"},   ifc.fetch_count, 32'h0);
        chk({tag, "_addr"},  ifc.imem_addr,   32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ifc.stall          = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;
        tick();
        tick();
        chk_reset("rst");

        // reset beats a simultaneous redirect
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h40;
        tick();
        chk("rst_redir_addr", ifc.imem_addr, 32'h0);

        // release; redirect during BOOT is ignored
        reset = 1'b0;
        tick();
        chk("boot_valid", {31'd0, ifc.if_valid}, 32'h0);
        chk("boot_addr",  ifc.imem_addr, 32'h0);
        ifc.redirect_valid = 1'b0;

        tick();
        chk("s0_pc",    ifc.if_pc, 32'h0);
        chk("s0_instr", ifc.if_instr, 32'h0011_0233);
        chk("s0_valid", {31'd0, ifc.if_valid}, 32'h1);
        chk("s0_p4",    ifc.if_pc_plus4, 32'h4);
        tick();
        chk("s1_pc",    ifc.if_pc, 32'h4);
        chk("s1_instr", ifc.if_instr, rom(32'h4));
        tick();
        chk("s2_pc",    ifc.if_pc, 32'h8);
        chk("s2_cnt",   ifc.fetch_count, 32'd3);
        chk("s2_addr",  ifc.imem_addr, 32'hC);

        // stall three cycles
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_pc",    ifc.if_pc, 32'h8);
            chk("st_instr", ifc.if_instr, rom(32'h8));
            chk("st_cnt",   ifc.fetch_count, 32'd3);
            chk("st_addr",  ifc.imem_addr, 32'hC);
        end
        ifc.stall = 1'b0;
        tick();
        chk("rs_pc",   ifc.if_pc, 32'hC);
        chk("rs_cnt",  ifc.fetch_count, 32'd4);
        chk("rs_addr", ifc.imem_addr, 32'h10);

        // redirect to 0x74
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h74;
        tick();
        chk("rd_valid", {31'd0, ifc.if_valid}, 32'h0);
        chk("rd_instr", ifc.if_instr, 32'h0000_0013);
        chk("rd_pc",    ifc.if_pc, 32'hC);
        chk("rd_cnt",   ifc.fetch_count, 32'd4);
        chk("rd_addr",  ifc.imem_addr, 32'h74);
        ifc.redirect_valid = 1'b0;
        tick();
        chk("rd1_pc",    ifc.if_pc, 32'h74);
        chk("rd1_valid", {31'd0, ifc.if_valid}, 32'h1);
        chk("rd1_instr", ifc.if_instr, rom(32'h74));
        chk("rd1_cnt",   ifc.fetch_count, 32'd5);

        // redirect and stall together, unaligned target
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h7B;
        ifc.stall          = 1'b1;
        tick();
        chk("rs2_addr",  ifc.imem_addr, 32'h78);
        chk("rs2_valid", {31'd0, ifc.if_valid}, 32'h0);
        chk("rs2_instr", ifc.if_instr, 32'h0000_0013);
        ifc.redirect_valid = 1'b0;
        ifc.stall          = 1'b0;
        tick();
        chk("rs3_pc",  ifc.if_pc, 32'h78);
        chk("rs3_cnt", ifc.fetch_count, 32'd6);

        // wrap at the top of the address space
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        chk("wr_addr", ifc.imem_addr, 32'hFFFF_FFFC);
        ifc.redirect_valid = 1'b0;
        tick();
        chk("wr_pc",   ifc.if_pc, 32'hFFFF_FFFC);
        chk("wr_p4",   ifc.if_pc_plus4, 32'h0);
        chk("wr_addr2", ifc.imem_addr, 32'h0);
        tick();
        chk("wr1_pc",  ifc.if_pc, 32'h0);
        chk("wr1_p4",  ifc.if_pc_plus4, 32'h4);
        chk("wr1_cnt", ifc.fetch_count, 32'd8);

        // fresh stream, then reset during a stall at count 5
        reset = 1'b1;
        tick();
        chk_reset("rst2");
        reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("pre_cnt", ifc.fetch_count, 32'd5);
        chk("pre_pc",  ifc.if_pc, 32'h10);
        ifc.stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk_reset("mid");
        reset     = 1'b0;
        ifc.stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
